ifu_buf: RTL

IFU_BUF -- requirements
Module: ifu_buf

---
 rtl/ifu_buf_pkg.sv | 25 ++
 rtl/ifu_fifo.sv | 82 ++++++++
 rtl/ifu_buf.sv | 82 ++++++++
 3 files changed

// File: rtl/ifu_buf_pkg.sv
// ifu_buf_pkg
// Shared constants and types for the instruction-fetch buffer.
//   RESET_PC_DEFAULT    : fetch PC loaded by reset
//   DEPTH_MIN/DEPTH_MAX : legal fetch-queue depth range (power of two)
//   fetch_entry_t       : one queue entry, {pc, inst}, 64 bits
package ifu_buf_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IM_AW_DEFAULT    = 10;
    localparam int          DEPTH_DEFAULT    = 4;
    localparam int          DEPTH_MIN        = 2;
    localparam int          DEPTH_MAX        = 16;
    localparam int          ENTRY_W          = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // True when d is a supported queue depth.
    function automatic logic depth_legal(input int d);
        return (d >= DEPTH_MIN) && (d <= DEPTH_MAX) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
// Fetch-queue storage with read/write pointers and an occupancy count.
// The head entry is read straight out of the entry registers, so dout
// never depends combinationally on din.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push, pop   : enqueue din / dequeue head (both legal when full)
//   flush       : empty the queue; a pop in the same cycle is absorbed
//   din, dout   : entry in / queue head out
//   count       : number of valid entries, 0..DEPTH
module ifu_fifo
    import ifu_buf_pkg::*;
#(
    parameter int  WIDTH = ENTRY_W,
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entries are cleared on reset so the head reads as zero afterwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (push && (wptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers are exactly log2(DEPTH) bits and wrap on their own.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_buf.sv
// ifu_buf
// Instruction fetch unit with a small decoupling queue. A fetch PC drives
// a combinational instruction memory; each accepted word is queued with
// its PC and presented to decode from registered storage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   redirect_valid/_pc  : flush the queue and restart fetch at redirect_pc
//   im_addr / im_rdata  : instruction memory address / same-cycle data
//   out_valid/out_ready : head handshake towards decode
//   out_inst / out_pc   : head instruction word and its byte address
module ifu_buf
    import ifu_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IM_AW    = IM_AW_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fpc_q, fpc_d;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    fetch_entry_t     din;
    fetch_entry_t     dout;

    assign im_addr   = fpc_q[IM_AW-1:0];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams.
    assign push      = !redirect_valid && ((count < CNT_W'(DEPTH)) || pop);

    assign din.pc   = fpc_q;
    assign din.inst = im_rdata;

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q <= RESET_PC;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assign out_inst = dout.inst;
    assign out_pc   = dout.pc;

endmodule
